// File: rtl/keypad_entry.sv
// keypad_entry: collects up to three decimal key presses as an M:SS time value
// (mins, sec_tens, sec_ones), then hands that value to a downstream counter
// chain with a one-cycle active-low load strobe and tracks when it is running.
module keypad_entry (
  input  logic       clock,
  input  logic       clearn,
  input  logic [9:0] keypad,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_done,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] mins,
  output logic       loadn,
  output logic       running,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  // True when exactly one key line is asserted.
  function automatic logic is_one_hot(input logic [9:0] lines);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (lines[i]) n++;
    end
    return (n == 1);
  endfunction

  // Index of the asserted key line as a BCD digit (only meaningful if one-hot).
  function automatic logic [3:0] key_code(input logic [9:0] lines);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (lines[i]) code = 4'(i);
    end
    return code;
  endfunction

  state_t     state_q, state_d;
  logic [9:0] key_q, key_d;
  logic       armed_q, armed_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] mins_q, mins_d;
  logic [1:0] count_q, count_d;
  logic       loadn_q, loadn_d;
  logic       running_q, running_d;
  logic       err_q, err_d;

  logic       key_event;
  logic [3:0] key_val;
  logic       key_reject;
  logic       digits_nonzero;

  // Edge detection on the raw key lines: one event per fresh single-key press.
  // armed_q keeps the very first edge after reset from accepting a key, so the
  // previous-keypad register has sampled real input before it is trusted.
  always_comb begin
    key_d     = keypad;
    armed_d   = 1'b1;
    key_event = armed_q && is_one_hot(keypad) && (key_q == 10'd0);
    key_val   = key_code(keypad);
  end

  // A key is refused when shifting would push a digit above 5 into sec_tens,
  // or when all three digit positions are already filled.
  always_comb begin
    key_reject     = (sec_ones_q > 4'd5) || (count_q == 2'd3);
    digits_nonzero = (sec_ones_q != 4'd0) || (sec_tens_q != 4'd0) ||
                     (mins_q != 4'd0);
  end

  // Next-state, digit shift register, digit count and registered outputs.
  always_comb begin
    state_d    = state_q;
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    mins_d     = mins_q;
    count_d    = count_q;
    err_d      = 1'b0;

    if (cancel) begin
      state_d    = IDLE;
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      mins_d     = 4'd0;
      count_d    = 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Digits are all zero here, so the first key can never be refused.
          if (key_event) begin
            state_d    = ENTRY;
            mins_d     = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = key_val;
            count_d    = count_q + 2'd1;
          end
        end
        ENTRY: begin
          if (start) begin
            // A start in the same cycle as a key drops the key.
            if (digits_nonzero) state_d = LOAD;
          end else if (key_event) begin
            if (key_reject) begin
              err_d = 1'b1;
            end else begin
              mins_d     = sec_tens_q;
              sec_tens_d = sec_ones_q;
              sec_ones_d = key_val;
              count_d    = count_q + 2'd1;
            end
          end
        end
        LOAD: begin
          state_d = RUN;
        end
        RUN: begin
          if (timer_done) begin
            state_d    = IDLE;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            mins_d     = 4'd0;
            count_d    = 2'd0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    loadn_d   = (state_d != LOAD);
    running_d = (state_d == RUN);
  end

  // State and output registers, all cleared asynchronously by clearn.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q    <= IDLE;
      key_q      <= 10'd0;
      armed_q    <= 1'b0;
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      mins_q     <= 4'd0;
      count_q    <= 2'd0;
      loadn_q    <= 1'b1;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      armed_q    <= armed_d;
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      mins_q     <= mins_d;
      count_q    <= count_d;
      loadn_q    <= loadn_d;
      running_q  <= running_d;
      err_q      <= err_d;
    end
  end

  assign sec_ones = sec_ones_q;
  assign sec_tens = sec_tens_q;
  assign mins     = mins_q;
  assign loadn    = loadn_q;
  assign running  = running_q;
  assign err      = err_q;

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001: clock  input  1  system clock; all state updates on rising edge.
REQ-002: clearn  input  1  reset, asynchronous, active-low; forces all state and outputs to reset values immediately.
REQ-003: keypad  input  10  raw key lines; bit k high = decimal key k pressed.
REQ-004: start  input  1  active-high start request.
REQ-005: cancel  input  1  active-high cancel request.
REQ-006: timer_done  input  1  active-high; the downstream counter chain has reached zero.
REQ-007: sec_ones  output  4  BCD seconds-units digit (0-9).
REQ-008: sec_tens  output  4  BCD seconds-tens digit (0-5).
REQ-009: mins  output  4  BCD minutes digit (0-9).
REQ-010: loadn  output  1  synchronous load strobe to the counter chain, active-low, one cycle.
REQ-011: running  output  1  high while the counter chain owns the time value (RUN state).
REQ-012: err  output  1  one-cycle pulse on a rejected key.

Function
REQ-013: FSM states SHALL be IDLE, ENTRY, LOAD and RUN; state encoding is free.
REQ-014: Key event: keypad registered each cycle into key_q; event fires only when keypad is one-hot and key_q == 0; a held key yields exactly one event; multi-key patterns are ignored with no err.
REQ-015: Key code = index of the set bit (0-9), 4-bit BCD.
REQ-016: Accepted key shifts left: mins <= sec_tens, sec_tens <= sec_ones, sec_ones <= code; takes effect on the edge after the event.
REQ-017: Key rejected (err=1 one cycle, digits unchanged) if sec_ones > 5 at the event (sec_tens would exceed 5), or 3 digits already entered.
REQ-018: 2-bit digit count: +1 per accepted key, saturates at 3, cleared on entering IDLE.
REQ-019: IDLE: digits 0; accepted key -> ENTRY; start ignored.
REQ-020: ENTRY: keys shift per REQ-016; start with any digit nonzero -> LOAD; start with all digits 0 -> stay in ENTRY, no load.
REQ-021: LOAD: loadn=0 for exactly one cycle, digits held stable that cycle; next state RUN unconditionally.
REQ-022: RUN: running=1; key events ignored (no err); digits held; timer_done=1 -> IDLE; start ignored.
REQ-023: cancel in any state -> IDLE next edge, digits and count cleared, no loadn pulse.
REQ-024: Same-cycle priority: cancel > timer_done > start > key event; a lower-priority event in the same cycle is dropped, not queued.
REQ-025: loadn SHALL be registered (glitch-free), high in every state except LOAD.
REQ-026: Digits are always valid BCD; sec_tens never exceeds 5.

Reset
REQ-027: clearn=0 SHALL asynchronously force IDLE, sec_ones=sec_tens=mins=0, count=0, key_q=0, loadn=1, running=0, err=0.
REQ-028: After clearn rises, the first key event is accepted no earlier than the second rising edge (key_q must sample once).
REQ-029: clearn asserted during LOAD SHALL abort the pulse: loadn returns to 1 immediately.

Verification
REQ-030: Keys 1,3,0 (each held 3 cycles, released 2) then start -> mins=1, sec_tens=3, sec_ones=0; loadn low exactly one cycle; running=1 next cycle.
REQ-031: Keys 7 then 2 -> second key rejected, err one-cycle pulse, sec_ones stays 7; keypad=0b0000000101 -> no change, no err.
REQ-032: Keys 1,2,3,4 -> fourth rejected with err; digits 1,2,3 retained.
REQ-033: In RUN, press key 5 -> digits unchanged, no err; assert timer_done -> IDLE, digits 0, running=0.
REQ-034: start and cancel same cycle in ENTRY with digits 0,4,5 -> IDLE, digits 0, loadn never low.
REQ-035: Assert clearn mid-LOAD (asynchronous, between edges) -> loadn=1 and all outputs 0 without waiting for a clock edge.
